// File: rtl/mmm_output_framer.sv
// Narrows matmul results to DW bits, tags row/matrix ends, and
// emits them on an AXI-Stream master through a 2-entry skid buffer.
module mmm_output_framer #(
  parameter int OUTW   = 32,
  parameter int DW     = 16,
  parameter int M      = 7,
  parameter int N      = 9,
  parameter int SAT_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OUTW-1:0] IN_TDATA,
  input  logic            IN_TVALID,
  output logic            IN_TREADY,
  output logic [DW-1:0]   OUT_TDATA,
  output logic            OUT_TVALID,
  input  logic            OUT_TREADY,
  output logic            OUT_TLAST,
  output logic [1:0]      OUT_TUSER,
  output logic            frame_done,
  input  logic            sat_clr,
  output logic [15:0]     sat_count
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eom;
    logic          eor;
    logic          sat;
  } ent_t;

  ent_t        head_q, head_d;
  ent_t        tail_q, tail_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [15:0] sat_q, sat_d;
  logic        fd_q, fd_d;

  logic        push, pop;
  logic        last_col, last_row;
  logic        ovf;
  logic [OUTW-DW:0] top_bits;
  ent_t        new_e;

  assign IN_TREADY  = (cnt_q != 2'd2);
  assign OUT_TVALID = (cnt_q != 2'd0);
  assign OUT_TDATA  = head_q.data;
  assign OUT_TLAST  = head_q.eom;
  assign OUT_TUSER  = {head_q.sat, head_q.eor};
  assign frame_done = fd_q;
  assign sat_count  = sat_q;

  assign push = IN_TVALID & IN_TREADY;
  assign pop  = OUT_TVALID & OUT_TREADY;

  assign last_col = (col_q == CW'(N - 1));
  assign last_row = (row_q == RW'(M - 1));

  // Value fits in DW signed bits iff all bits from DW-1 upward agree.
  assign top_bits = IN_TDATA[OUTW-1:DW-1];
  assign ovf = (SAT_EN != 0) && !((&top_bits) || !(|top_bits));

  always_comb begin
    new_e.eor = last_col;
    new_e.eom = last_col & last_row;
    new_e.sat = ovf;
    if (!ovf)
      new_e.data = IN_TDATA[DW-1:0];
    else if (IN_TDATA[OUTW-1])
      new_e.data = {1'b1, {(DW-1){1'b0}}};
    else
      new_e.data = {1'b0, {(DW-1){1'b1}}};
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = new_e;
        else               tail_d = new_e;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = new_e;
        end else begin
          head_d = tail_q;
          tail_d = new_e;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (push) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (sat_clr)
      sat_d = '0;
    else if (push && new_e.sat && sat_q != 16'hFFFF)
      sat_d = sat_q + 16'd1;
  end

  assign fd_d = pop & head_q.eom;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      sat_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      col_q  <= col_d;
      row_q  <= row_d;
      sat_q  <= sat_d;
      fd_q   <= fd_d;
    end
  end

endmodule
